// File: rtl/alu_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_accumulator_if
//  Description : ALU-result input and group-sum output handshakes of the
//                neuron partial-sum accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_accumulator_if #(
    parameter int NBITS = 15,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [NBITS+1:0]   in_y;
    logic               in_co;
    logic               clear;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_sat;
    logic [CNT_W-1:0]   out_co_cnt;

    modport master (
        output in_valid, in_y, in_co, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_co_cnt
    );

    modport slave (
        input  in_valid, in_y, in_co, clear, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_co_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : alu_accumulator
//  Description : Sums NUM_TERMS ALU results into a signed saturating
//                accumulator and hands each group sum downstream.
//                Optional macro ALU_ACC_RELU_EN rectifies the output sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_accumulator #(
    parameter int NBITS     = 15,
    parameter int ACC_W     = 24,
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int               c_ext_w     = ACC_W + 1 - (NBITS + 2);
    localparam logic [CNT_W-1:0] c_num_terms = CNT_W'(NUM_TERMS);
    localparam logic [ACC_W-1:0] c_max       = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_min       = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_co_cnt, w_co_cnt_nxt;
    logic               r_sat, w_sat_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [ACC_W-1:0]   r_out_sum, w_out_sum_nxt;
    logic               r_out_sat, w_out_sat_nxt;
    logic [CNT_W-1:0]   r_out_co_cnt, w_out_co_cnt_nxt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_in_accum;
    logic [ACC_W:0]     w_y_ext;
    logic [ACC_W:0]     w_base;
    logic [ACC_W:0]     w_sum_raw;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_sum_sat;
    logic [ACC_W-1:0]   w_out_val;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_co_inc;
    logic               w_sat_acc;

    assign w_in_ready = (r_state != S_DONE) && !bus.clear;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_in_accum = (r_state == S_ACCUM);

    // The first term of a group starts from zero, so it can never saturate.
    assign w_y_ext   = {{c_ext_w{bus.in_y[NBITS+1]}}, bus.in_y};
    assign w_base    = w_in_accum ? {r_acc[ACC_W-1], r_acc} : '0;
    assign w_sum_raw = w_base + w_y_ext;
    assign w_ovf     = w_sum_raw[ACC_W] ^ w_sum_raw[ACC_W-1];
    assign w_sum_sat = w_ovf ? (w_sum_raw[ACC_W] ? c_min : c_max)
                             : w_sum_raw[ACC_W-1:0];

    assign w_cnt_inc = (w_in_accum ? r_cnt : '0) + CNT_W'(1);
    assign w_co_inc  = (w_in_accum ? r_co_cnt : '0) + CNT_W'(bus.in_co);
    assign w_sat_acc = (w_in_accum && r_sat) || w_ovf;

`ifdef ALU_ACC_RELU_EN
    assign w_out_val = w_sum_sat[ACC_W-1] ? '0 : w_sum_sat;
`else
    assign w_out_val = w_sum_sat;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_cnt_nxt        = r_cnt;
        w_co_cnt_nxt     = r_co_cnt;
        w_sat_nxt        = r_sat;
        w_out_valid_nxt  = r_out_valid;
        w_out_sum_nxt    = r_out_sum;
        w_out_sat_nxt    = r_out_sat;
        w_out_co_cnt_nxt = r_out_co_cnt;

        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt    = w_sum_sat;
                    w_cnt_nxt    = w_cnt_inc;
                    w_co_cnt_nxt = w_co_inc;
                    w_sat_nxt    = w_sat_acc;
                    if (w_cnt_inc == c_num_terms) begin
                        w_out_sum_nxt    = w_out_val;
                        w_out_sat_nxt    = w_sat_acc;
                        w_out_co_cnt_nxt = w_co_inc;
                        w_out_valid_nxt  = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over any transition above; out_sum keeps its last value.
        if (bus.clear) begin
            w_state_nxt     = S_IDLE;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_co_cnt_nxt    = '0;
            w_sat_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_co_cnt     <= '0;
            r_sat        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_sat    <= 1'b0;
            r_out_co_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_co_cnt     <= w_co_cnt_nxt;
            r_sat        <= w_sat_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_sum    <= w_out_sum_nxt;
            r_out_sat    <= w_out_sat_nxt;
            r_out_co_cnt <= w_out_co_cnt_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sum    = r_out_sum;
    assign bus.out_sat    = r_out_sat;
    assign bus.out_co_cnt = r_out_co_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_accumulator
//  Description : Directed and random stimulus for alu_accumulator against a
//                group-level saturating-sum reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accumulator;

    localparam int NBITS     = 15;
    localparam int ACC_W     = 18;
    localparam int NUM_TERMS = 4;
    localparam int CNT_W     = 8;

    localparam longint SMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (ACC_W-1));
    localparam int     YMAX = 65535;
    localparam int     YMIN = -65536;

`ifdef ALU_ACC_RELU_EN
    localparam longint EXP_NEG_GRP = 0;
    localparam longint EXP_MIN_GRP = 0;
`else
    localparam longint EXP_NEG_GRP = -40;
    localparam longint EXP_MIN_GRP = -131072;
`endif

    logic clk;
    logic rst;

    alu_accumulator_if #(.NBITS(NBITS), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    alu_accumulator #(
        .NBITS     (NBITS),
        .ACC_W     (ACC_W),
        .NUM_TERMS (NUM_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the terms of the open group plus the last handed-off result.
    int     grp_y[$];
    bit     grp_co[$];
    bit     m_done;
    longint m_out_sum;
    bit     m_out_sat;
    int     m_out_co;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic finish_group();
        longint a = 0;
        bit     s = 0;
        int     c = 0;
        foreach (grp_y[i]) begin
            a = a + grp_y[i];
            if (a > SMAX) begin a = SMAX; s = 1; end
            if (a < SMIN) begin a = SMIN; s = 1; end
            c = c + int'(grp_co[i]);
        end
`ifdef ALU_ACC_RELU_EN
        if (a < 0) a = 0;
`endif
        m_out_sum = a;
        m_out_sat = s;
        m_out_co  = c;
        m_done    = 1;
        grp_y.delete();
        grp_co.delete();
    endtask

    task automatic model_edge(input bit v, input int y, input bit co,
                              input bit ordy, input bit clr, input bit r);
        if (r) begin
            grp_y.delete(); grp_co.delete();
            m_done = 0; m_out_sum = 0; m_out_sat = 0; m_out_co = 0;
        end else if (clr) begin
            grp_y.delete(); grp_co.delete();
            m_done = 0;
        end else if (m_done) begin
            if (ordy) m_done = 0;
        end else if (v) begin
            grp_y.push_back(y);
            grp_co.push_back(co);
            if (grp_y.size() == NUM_TERMS) finish_group();
        end
    endtask

    // One clock: apply inputs, check in_ready, clock, then check outputs.
    task automatic cycle(input bit v, input int y, input bit co,
                         input bit ordy, input bit clr, input bit r);
        rst           = r;
        bus.in_valid  = v;
        bus.in_y      = y[NBITS+1:0];
        bus.in_co     = co;
        bus.out_ready = ordy;
        bus.clear     = clr;
        #1;
        if (!r) check_eq("in_ready", longint'(bus.in_ready), longint'(!m_done && !clr));
        @(posedge clk);
        model_edge(v, y, co, ordy, clr, r);
        #1;
        check_eq("out_valid", longint'(bus.out_valid), longint'(m_done));
        check_eq("out_sum", longint'($signed(bus.out_sum)), m_out_sum);
        if (m_done) begin
            check_eq("out_sat", longint'(bus.out_sat), longint'(m_out_sat));
            check_eq("out_co_cnt", longint'(bus.out_co_cnt), longint'(m_out_co));
        end
    endtask

    task automatic feed(input int y, input bit co);
        cycle(1'b1, y, co, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        m_done = 0; m_out_sum = 0; m_out_sat = 0; m_out_co = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_y = '0; bus.in_co = 1'b0;
        bus.out_ready = 1'b0; bus.clear = 1'b0;

        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_out_valid", longint'(bus.out_valid), 0);
        check_eq("rst_in_ready", longint'(bus.in_ready), 1);

        // Basic group with carries
        feed(10, 1'b0); feed(20, 1'b1); feed(30, 1'b0); feed(-5, 1'b1);
        check_eq("tp1_sum", longint'($signed(bus.out_sum)), 55);
        check_eq("tp1_co", longint'(bus.out_co_cnt), 2);
        idle_cycle();
        check_eq("tp1_back_idle", longint'(bus.out_valid), 0);

        // Saturation at both bounds, then a clean group
        repeat (4) feed(YMAX, 1'b0);
        check_eq("tp2_max", longint'($signed(bus.out_sum)), 131071);
        check_eq("tp2_max_sat", longint'(bus.out_sat), 1);
        idle_cycle();
        repeat (4) feed(YMIN, 1'b1);
        check_eq("tp2_min", longint'($signed(bus.out_sum)), EXP_MIN_GRP);
        check_eq("tp2_min_sat", longint'(bus.out_sat), 1);
        idle_cycle();
        repeat (4) feed(1, 1'b0);
        check_eq("tp2_ones", longint'($signed(bus.out_sum)), 4);
        check_eq("tp2_ones_sat", longint'(bus.out_sat), 0);
        idle_cycle();

        // Backpressure with in_valid held high
        feed(1, 1'b0); feed(2, 1'b0); feed(3, 1'b0);
        cycle(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 77, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("tp3_hold", longint'($signed(bus.out_sum)), 10);
        cycle(1'b1, 77, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("tp3_drop", longint'(bus.out_valid), 0);
        cycle(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Gaps between terms
        feed(7, 1'b0); idle_cycle(); idle_cycle(); feed(8, 1'b0);
        idle_cycle(); feed(9, 1'b0); feed(10, 1'b0);
        check_eq("tp4_gaps", longint'($signed(bus.out_sum)), 34);
        idle_cycle();

        // Abort by clear, abort by reset, reset in DONE
        feed(100, 1'b0); feed(200, 1'b0);
        cycle(1'b1, 999, 1'b1, 1'b1, 1'b1, 1'b0);
        feed(1, 1'b0); feed(2, 1'b0); feed(3, 1'b0); feed(4, 1'b0);
        check_eq("tp5_clear", longint'($signed(bus.out_sum)), 10);
        idle_cycle();
        feed(100, 1'b0); feed(200, 1'b0);
        cycle(1'b1, 999, 1'b1, 1'b1, 1'b0, 1'b1);
        feed(1, 1'b0); feed(2, 1'b0); feed(3, 1'b0); feed(4, 1'b0);
        check_eq("tp5_rst", longint'($signed(bus.out_sum)), 10);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("tp5_rst_done_v", longint'(bus.out_valid), 0);
        check_eq("tp5_rst_done_s", longint'($signed(bus.out_sum)), 0);

        // Negative group (rectified when the option is built in)
        feed(-10, 1'b0); feed(-20, 1'b0); feed(-30, 1'b0); feed(20, 1'b0);
        check_eq("tp6_neg", longint'($signed(bus.out_sum)), EXP_NEG_GRP);
        idle_cycle();
        feed(5, 1'b0); feed(5, 1'b0); feed(5, 1'b0); feed(5, 1'b0);
        check_eq("tp6_pos", longint'($signed(bus.out_sum)), 20);
        idle_cycle();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int  y;
            int  pick;
            bit  v, co, ordy, clr, r;
            pick = int'($urandom_range(0, 5));
            if (pick == 0)      y = YMAX;
            else if (pick == 1) y = YMIN;
            else                y = int'($urandom_range(0, 131071)) - 65536;
            v    = ($urandom_range(0, 9) < 7);
            co   = $urandom_range(0, 1) == 1;
            ordy = ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 99) < 3);
            r    = ($urandom_range(0, 199) < 1);
            cycle(v, y, co, ordy, clr, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
